// File: rtl/fp_add_align.sv
// Two-stage pre-alignment front end for the single-precision FP adder:
// stage 1 unpacks and orders the operands by magnitude, stage 2 aligns the smaller significand.
module fp_add_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [23:0] out_man_l,
    output logic [26:0] out_man_s,
    output logic        out_eff_sub,
    output logic        out_nan,
    output logic        out_inf
);

    logic        s1_valid;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;

    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_man_l;
    logic [23:0] s1_man_s;
    logic [7:0]  s1_d;
    logic        s1_eff_sub;
    logic        s1_nan;
    logic        s1_inf;

    logic [7:0]  a_exp_eff;
    logic [7:0]  b_exp_eff;
    logic [23:0] a_man;
    logic [23:0] b_man;
    logic        a_is_nan;
    logic        b_is_nan;
    logic        a_is_inf;
    logic        b_is_inf;
    logic        a_large;
    logic        nan_in;
    logic        inf_in;

    logic [26:0] man_s_ext;
    logic [26:0] man_s_shifted;
    logic [26:0] shift_mask;
    logic        shift_lost;
    logic [26:0] man_s_aligned;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Denormals and zero share the effective exponent 1 with a cleared hidden bit.
    always_comb begin
        a_exp_eff = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        b_exp_eff = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        a_man     = {(a[30:23] != 8'd0), a[22:0]};
        b_man     = {(b[30:23] != 8'd0), b[22:0]};
        a_is_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_is_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_is_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_is_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_large   = (a[30:0] >= b[30:0]);
        nan_in    = a_is_nan || b_is_nan || (a_is_inf && b_is_inf && (a[31] != b[31]));
        inf_in    = !nan_in && (a_is_inf || b_is_inf);
    end

    // Stage 1: magnitude ordering; infinity always wins the compare, so out_sign follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= 8'd0;
            s1_man_l   <= 24'd0;
            s1_man_s   <= 24'd0;
            s1_d       <= 8'd0;
            s1_eff_sub <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_eff_sub <= a[31] ^ b[31];
                s1_nan     <= nan_in;
                s1_inf     <= inf_in;
                if (a_large) begin
                    s1_sign  <= a[31];
                    s1_exp   <= a_exp_eff;
                    s1_man_l <= a_man;
                    s1_man_s <= b_man;
                    s1_d     <= a_exp_eff - b_exp_eff;
                end else begin
                    s1_sign  <= b[31];
                    s1_exp   <= b_exp_eff;
                    s1_man_l <= b_man;
                    s1_man_s <= a_man;
                    s1_d     <= b_exp_eff - a_exp_eff;
                end
            end
        end
    end

    // Alignment shift; every bit pushed past the sticky position folds into bit 0.
    always_comb begin
        man_s_ext     = {s1_man_s, 3'b000};
        man_s_shifted = 27'd0;
        shift_mask    = 27'd0;
        shift_lost    = 1'b0;
        man_s_aligned = 27'd0;
        if (s1_d >= 8'd27) begin
            man_s_aligned = {26'd0, |s1_man_s};
        end else begin
            man_s_shifted = man_s_ext >> s1_d[4:0];
            shift_mask    = ~({27{1'b1}} << s1_d[4:0]);
            shift_lost    = |(man_s_ext & shift_mask);
            man_s_aligned = {man_s_shifted[26:1], man_s_shifted[0] | shift_lost};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= 8'd0;
            out_man_l   <= 24'd0;
            out_man_s   <= 27'd0;
            out_eff_sub <= 1'b0;
            out_nan     <= 1'b0;
            out_inf     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign    <= s1_sign;
                out_exp     <= s1_exp;
                out_man_l   <= s1_man_l;
                out_man_s   <= man_s_aligned;
                out_eff_sub <= s1_eff_sub;
                out_nan     <= s1_nan;
                out_inf     <= s1_inf;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_align.sv
// Directed self-checking bench for fp_add_align: datapath vectors, specials,
// backpressure and mid-flight reset, all expectations computed by hand.
module tb_fp_add_align;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_man_l;
    logic [26:0] out_man_s;
    logic        out_eff_sub;
    logic        out_nan;
    logic        out_inf;

    int tests_run = 0;
    int tests_failed = 0;

    fp_add_align dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_man_l   (out_man_l),
        .out_man_s   (out_man_s),
        .out_eff_sub (out_eff_sub),
        .out_nan     (out_nan),
        .out_inf     (out_inf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Offer one pair from a negedge; returns at the negedge after acceptance with in_valid low.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb);
        bit accepted;
        accepted = 1'b0;
        a = va;
        b = vb;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (in_ready) accepted = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    // Full datapath vector with out_ready high: checks the 2-cycle latency too.
    task automatic runVector(input string tag, input logic [31:0] va, input logic [31:0] vb,
                             input logic e_sign, input logic [7:0] e_exp, input logic [23:0] e_man_l,
                             input logic [26:0] e_man_s, input logic e_sub);
        applyStimulus(va, vb);
        checkOutput({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, "_data"},
                    {1'b0, out_sign, out_exp, out_man_l, out_man_s, out_eff_sub, out_nan, out_inf},
                    {1'b0, e_sign, e_exp, e_man_l, e_man_s, e_sub, 1'b0, 1'b0});
        @(negedge clk);
    endtask

    task automatic runSpecial(input string tag, input logic [31:0] va, input logic [31:0] vb,
                              input logic e_nan, input logic e_inf, input logic e_sign);
        applyStimulus(va, vb);
        @(negedge clk);
        checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, "_flags"}, {62'd0, out_nan, out_inf}, {62'd0, e_nan, e_inf});
        if (e_inf) checkOutput({tag, "_sign"}, {63'd0, out_sign}, {63'd0, e_sign});
        @(negedge clk);
    endtask

    int stale;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'd0;
        b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_data", {1'b0, out_sign, out_exp, out_man_l, out_man_s, out_eff_sub, out_nan, out_inf}, 64'd0);

        runVector("equal_exp", 32'hC1040001, 32'hC1008001, 1'b1, 8'd130, 24'h840001, 27'h4040008, 1'b0);
        runVector("small_shift", 32'h3F800000, 32'h41000000, 1'b0, 8'd130, 24'h800000, 27'h0800000, 1'b0);
        runVector("large_shift", 32'h4B800000, 32'hB3800001, 1'b0, 8'd151, 24'h800000, 27'h0000001, 1'b1);
        runVector("shift_d25", 32'h4D800000, 32'h41000001, 1'b0, 8'd155, 24'h800000, 27'h0000003, 1'b0);
        runVector("shift_d27", 32'h4E800000, 32'h41000000, 1'b0, 8'd157, 24'h800000, 27'h0000001, 1'b0);
        runVector("denormals", 32'h00000003, 32'h00000001, 1'b0, 8'd1, 24'h000003, 27'h0000008, 1'b0);
        runVector("tie_a_wins", 32'h40400000, 32'hC0400000, 1'b0, 8'd128, 24'hC00000, 27'h6000000, 1'b1);

        runSpecial("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 1'b0);
        runSpecial("neg_inf", 32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 1'b1);
        runSpecial("qnan", 32'h7FC00000, 32'h3F800000, 1'b1, 1'b0, 1'b0);
        runSpecial("b_inf", 32'h3F800000, 32'h7F800000, 1'b0, 1'b1, 1'b0);

        // Backpressure: three back-to-back pairs with exponents 127, 128, 129.
        out_ready = 1'b0;
        a = 32'h3F800000; b = 32'd0; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_after1", {63'd0, in_ready}, 64'd1);
        a = 32'h40000000;
        @(negedge clk);
        checkOutput("bp_full_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_out_p1", {55'd0, out_valid, out_exp}, {55'd0, 1'b1, 8'd127});
        a = 32'h40800000;
        @(negedge clk);
        checkOutput("bp_still_full", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_stable_p1", {31'd0, out_valid, out_exp, out_man_l},
                    {31'd0, 1'b1, 8'd127, 24'h800000});
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_out_p2", {55'd0, out_valid, out_exp}, {55'd0, 1'b1, 8'd128});
        @(negedge clk);
        checkOutput("bp_out_p3", {55'd0, out_valid, out_exp}, {55'd0, 1'b1, 8'd129});
        @(negedge clk);
        checkOutput("bp_drained", {63'd0, out_valid}, 64'd0);

        // Reset with both stages full and downstream stalled.
        out_ready = 1'b0;
        a = 32'h41000000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_full", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_exp", {56'd0, out_exp}, 64'd0);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rst_no_stale", stale, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
